// File: rtl/parity_check_rx_if.sv
// parity_check_rx_if: serial bit input, byte output handshake and error status of parity_check_rx
interface parity_check_rx_if #(parameter int ERR_CNT_W = 8);
  logic bit_in;
  logic bit_valid;
  logic frame_start;
  logic clear_err;
  logic [7:0] data_out;
  logic parity_err;
  logic out_valid;
  logic out_ready;
  logic overrun;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    output bit_in, bit_valid, frame_start, clear_err, out_ready,
    input  data_out, parity_err, out_valid, overrun, err_count
  );
  modport slave (
    input  bit_in, bit_valid, frame_start, clear_err, out_ready,
    output data_out, parity_err, out_valid, overrun, err_count
  );
endinterface

// File: rtl/parity_check_rx.sv
// parity_check_rx: deserializes 8 data bits (LSB first) plus parity, flags parity errors; PARITY_ODD_EN selects odd parity
module parity_check_rx #(
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic reset,
  parity_check_rx_if.slave bus
);
`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic done, err, load;
  logic [7:0] data_q;
  logic perr_q, valid_q, ovr_q;
  logic [ERR_CNT_W-1:0] err_q;
  // frame state, bit position and data shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      sh <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
    end
  end
  // frame_start with a valid bit always restarts; otherwise only valid bits advance the frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    done = 1'b0;
    if (bus.bit_valid) begin
      if (bus.frame_start) begin
        state_n = DATA;
        cnt_n = 3'd1;
        sh_n = {7'd0, bus.bit_in};
      end else if (state == DATA) begin
        sh_n[cnt] = bus.bit_in;
        cnt_n = cnt + 3'd1;
        state_n = (cnt == 3'd7) ? PARITY : DATA;
      end else if (state == PARITY) begin
        done = 1'b1;
        cnt_n = 3'd0;
        state_n = IDLE;
      end
    end
  end
  assign err = ^{sh, bus.bit_in} ^ ODD;
  assign load = done & (~valid_q | bus.out_ready);
  // output holding register, handshake, sticky overrun and saturating error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= 8'd0;
      perr_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      err_q <= '0;
    end else begin
      data_q <= load ? sh : data_q;
      perr_q <= load ? err : perr_q;
      valid_q <= load | (valid_q & ~bus.out_ready);
      ovr_q <= ~bus.clear_err & (ovr_q | (done & ~load));
      err_q <= bus.clear_err ? '0 : err_q + ERR_CNT_W'(done & err & ~&err_q);
    end
  end
  assign bus.data_out = data_q;
  assign bus.parity_err = perr_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun = ovr_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: randomized and directed checks of parity_check_rx against a frame-level model
module tb_parity_check_rx;
`ifdef PARITY_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  parity_check_rx_if #(.ERR_CNT_W(8)) bus ();
  parity_check_rx_if #(.ERR_CNT_W(2)) bus2 ();
  assign bus2.bit_in = bus.bit_in;
  assign bus2.bit_valid = bus.bit_valid;
  assign bus2.frame_start = bus.frame_start;
  assign bus2.clear_err = bus.clear_err;
  assign bus2.out_ready = bus.out_ready;
  parity_check_rx #(.ERR_CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  parity_check_rx #(.ERR_CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  int tests = 0;
  int fails = 0;
  bit rdy = 1'b1;
  bit rand_mode = 1'b0;
  int q[$];
  bit in_frame = 1'b0;
  logic [7:0] m_data = 8'd0;
  logic m_perr = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
  int m_cnt = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("err_count", 32'(bus.err_count), 32'(m_cnt > 255 ? 255 : m_cnt));
    chk("err_count_w2", 32'(bus2.err_count), 32'(m_cnt > 3 ? 3 : m_cnt));
  endtask
  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    m_data = 8'd0;
    m_perr = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_cnt = 0;
  endtask
  task automatic model_update(input bit bv, input bit bi, input bit fs, input bit clr, input bit r);
    bit done = 1'b0;
    bit err = 1'b0;
    logic [7:0] d = 8'd0;
    if (bv) begin
      if (fs) begin
        q.delete();
        q.push_back(int'(bi));
        in_frame = 1'b1;
      end else if (in_frame) begin
        q.push_back(int'(bi));
        if (q.size() == 9) begin
          for (int i = 0; i < 8; i++) d[i] = q[i][0];
          err = ((($countones(d) + q[8]) % 2) != int'(ODD));
          done = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_data = d;
        m_perr = err;
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
    end else if (m_valid && r) m_valid = 1'b0;
    if (clr) begin
      m_cnt = 0;
      m_ovr = 1'b0;
    end else if (done && err) m_cnt++;
  endtask
  task automatic step(input bit bv, input bit bi, input bit fs, input bit clr);
    bit c;
    c = clr | (rand_mode && $urandom_range(0, 19) == 0);
    if (rand_mode) rdy = 1'($urandom);
    bus.bit_valid = bv;
    bus.bit_in = bi;
    bus.frame_start = fs;
    bus.clear_err = c;
    bus.out_ready = rdy;
    @(posedge clk);
    model_update(bv, bi, fs, c, rdy);
    #1;
    check_all();
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.clear_err = 1'b0;
  endtask
  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
  endtask
  task automatic send_frame(input logic [7:0] d, input bit p, input bit gaps, input bit clr_last);
    step(1'b1, d[0], 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      gap(gaps);
      step(1'b1, d[i], 1'b0, 1'b0);
    end
    gap(gaps);
    step(1'b1, p, 1'b0, clr_last);
  endtask
  function automatic bit bad_p(input logic [7:0] d);
    return ^d ^ ODD ^ 1'b1;
  endfunction
  initial begin
    logic [7:0] d;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.clear_err = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_data", 32'(bus.data_out), 32'h A5);
    chk("a5_valid", 32'(bus.out_valid), 32'd1);
    chk("a5_perr", 32'(bus.parity_err), 32'(ODD));
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    chk("07_data", 32'(bus.data_out), 32'h07);
    chk("07_perr", 32'(bus.parity_err), 32'(!ODD));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_count", 32'(bus.err_count), 32'd0);
    rdy = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    chk("bp_data_held", 32'(bus.data_out), 32'h11);
    chk("bp_overrun", 32'(bus.overrun), 32'd1);
    rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_consumed", 32'(bus.out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_ovr_clear", 32'(bus.overrun), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("restart_data", 32'(bus.data_out), 32'h3C);
    chk("restart_perr", 32'(bus.parity_err), 32'(ODD));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("gaps_data", 32'(bus.data_out), 32'h3C);
    chk("gaps_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send_frame(8'h5A ^ 8'(k), bad_p(8'h5A ^ 8'(k)), 1'b0, 1'b0);
    chk("sat_w2", 32'(bus2.err_count), 32'd3);
    chk("cnt_w8", 32'(bus.err_count), 32'd4);
    send_frame(8'h81, bad_p(8'h81), 1'b0, 1'b1);
    chk("clr_priority", 32'(bus.err_count), 32'd0);
    chk("clr_priority_w2", 32'(bus2.err_count), 32'd0);
    rand_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1, 1'($urandom), 1'b1, 1'b0);
        repeat ($urandom_range(0, 7)) step(1'b1, 1'($urandom), 1'b0, 1'b0);
      end
      send_frame(d, 1'($urandom), 1'($urandom), 1'b0);
    end
    rand_mode = 1'b0;
    rdy = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.data_out), 32'hC3);
    chk("post_rst_perr", 32'(bus.parity_err), 32'(ODD));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/parity_check_rx.md
# parity_check_rx

Serial receive-side companion to the team's 8-bit parity generator. It deserializes a framed bit stream of 8 data bits (LSB first) followed by one parity bit, and recomputes parity over the data. It presents each byte with a parity-error flag on a valid/ready output port, and keeps a saturating error counter and a sticky overrun flag. It sits between the serial link front end and the byte-consuming logic.

## Interface
- `ERR_CNT_W`, default 8: width of the parity-error counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bit_in` in 1: serial data, sampled only when `bit_valid`=1.
- `bit_valid` in 1: qualifies `bit_in` for one cycle.
- `frame_start` in 1: with `bit_valid`=1, marks `bit_in` as data bit 0 of a new frame.
- `clear_err` in 1: synchronous clear of `err_count` and `overrun`.
- `data_out` out 8: received byte.
- `parity_err` out 1: parity mismatch for `data_out`.
- `out_valid` out 1: `data_out` and `parity_err` are valid.
- `out_ready` in 1: consumer accepts the output when `out_valid`=1.
- `overrun` out 1: sticky; a completed frame was dropped.
- `err_count` out `ERR_CNT_W`: saturating count of frames with parity errors.

## Operation
- Reset values:
  - All outputs are 0 (`data_out`=0x00, `parity_err`=0, `out_valid`=0, `overrun`=0, `err_count`=0).
  - FSM is in IDLE; bit counter is 0; shift register is 0x00.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - `bit_valid`=1 and `frame_start`=0: the bit is ignored.
  - `bit_valid`=1 and `frame_start`=1: store the bit as data[0], set count=1, go to DATA.
- DATA:
  - Each `bit_valid` stores `bit_in` at data[count] and increments count.
  - When data[7] is stored, go to PARITY.
- PARITY:
  - The next `bit_valid` is the parity bit `p`.
  - Check value: c = XOR(data[7:0]) ^ p.
  - Even mode: error = (c≠0).
  - The frame is complete; go to IDLE.
- Restart: `frame_start`=1 with `bit_valid`=1 in DATA or PARITY abandons the partial frame without flagging or counting it. The bit is taken as data[0] of the new frame, count=1, state is DATA.
- Cycles with `bit_valid`=0 never advance the FSM, whatever `frame_start` is.
- Frame completion, output free (`out_valid`=0, or `out_ready`=1 on the same edge):
  - Load `data_out` and `parity_err`.
  - Set `out_valid`=1.
- Frame completion, output occupied (`out_valid`=1 and `out_ready`=0):
  - The new frame is dropped and `overrun` is set.
  - The held output is unchanged.
- `err_count` increments by 1 on every completed frame with an error, whether loaded or dropped. It saturates at 2^`ERR_CNT_W`−1.
- Handshake:
  - `out_valid`=1 and `out_ready`=1 at an edge consumes the output.
  - `out_valid` then falls, unless a new frame loads on the same edge; in that case it stays 1 with the new data.
- `clear_err`=1: `err_count` and `overrun` go to 0 on the next edge. This takes priority over a simultaneous increment or overrun set.

## Timing
- Latency: parity bit sampled at edge N → `out_valid`=1, `data_out` and `parity_err` updated, visible after edge N.
- `err_count` and `overrun` update at the same edge N.
- Minimum frame is 9 consecutive `bit_valid` cycles. Back-to-back frames are supported with zero idle cycles.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- `reset` asserted mid-frame or mid-handshake clears everything immediately (asynchronously). The partial frame is lost and not counted.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `PARITY_ODD_EN` defined: odd parity expected; error = (c≠1), i.e. the nine bits must contain an odd number of ones.
- `PARITY_ODD_EN` not defined: even parity expected; error = (c≠0). This matches the generator's output.

## Test plan
- Even parity, no error: `frame_start` plus bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then p=0 → one cycle later `out_valid`=1, `data_out`=0xA5, `parity_err`=0, `err_count`=0.
- Parity error: 0x07 with p=0 → `parity_err`=1, `err_count`=1.
- Under `PARITY_ODD_EN`: 0x07 with p=0 → `parity_err`=0.
- Backpressure, `out_ready`=0:
  - Send 0x11 (p=0), then 0x22 (p=0) back-to-back → `data_out` stays 0x11, `overrun`=1.
  - Raise `out_ready` for one cycle → `out_valid`=0.
  - Pulse `clear_err` → `overrun`=0.
- Restart and gaps:
  - `frame_start` after 5 bits, then a full 0x3C frame (p=0) → only 0x3C is output, `parity_err`=0.
  - Random `bit_valid`=0 gaps between bits, including `frame_start`=1 while `bit_valid`=0 → the result is identical.
- Counters and reset:
  - With `ERR_CNT_W`=2, send 4 bad frames → `err_count`=3 (saturated).
  - `clear_err` on the same edge as a bad frame completing → `err_count`=0.
  - `reset` after 4 data bits → all outputs are 0 immediately; the next full frame decodes correctly.
